// File: rtl/sipo_deser_rx.sv
// sipo_deser_rx: serial-to-parallel word receiver with MSB/LSB-first framing and a one-entry valid/ready output.
// Optional macro PARITY_CHECK_EN appends a parity bit per word and reports parity_err.
module sipo_deser_rx #(
  parameter int WIDTH      = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_abort,
  output logic             parity_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAR   = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0] state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr, sr_shift, word;
  logic lsb_mode, mode_nx, start, last, commit, perr_nx;
  assign start    = ser_valid && frame_start;
  assign mode_nx  = (state == IDLE || start) ? lsb_first : lsb_mode;
  assign sr_shift = mode_nx ? {ser_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], ser_in};
  assign last     = ser_valid && !frame_start && state == SHIFT && cnt == CW'(WIDTH - 1);
  assign busy     = state != IDLE;
`ifdef PARITY_CHECK_EN
  localparam logic [1:0] DONE_ST = PAR;
  assign commit  = ser_valid && !frame_start && state == PAR;
  assign word    = sr;
  assign perr_nx = ^{sr, ser_in} ^ PARITY_ODD;
`else
  localparam logic [1:0] DONE_ST = IDLE;
  assign commit  = last;
  assign word    = sr_shift;
  assign perr_nx = PARITY_ODD & 1'b0;
`endif
  // a frame_start always wins over completing or parity-checking the current word
  always_comb
    state_nx = start ? SHIFT : last ? DONE_ST : (state == PAR && ser_valid) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      lsb_mode    <= 1'b0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      state       <= state_nx;
      overrun     <= commit && out_valid && !out_ready;
      frame_abort <= start && state != IDLE;
      if (start) begin
        cnt      <= CW'(1);
        lsb_mode <= lsb_first;
        sr       <= sr_shift;
      end else if (ser_valid && state == SHIFT) begin
        cnt <= cnt + 1'b1;
        sr  <= sr_shift;
      end
      if (commit && (!out_valid || out_ready)) begin
        data_out   <= word;
        out_valid  <= 1'b1;
        parity_err <= perr_nx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule
